// File: rtl/llc_cmd_scheduler.sv
// LLC command front-end: L1 request FIFO + snoop holding register, snoop-priority arbiter with
// bounded L1 starvation, IDLE/ISSUE/WAIT issue FSM and completion watchdog. Optional: LLC_SCHED_STATS_EN.
module llc_cmd_scheduler #(
    parameter int ADDR_BITS        = 32,
    parameter int CMDSIZE          = 4,
    parameter int L1_FIFO_DEPTH    = 4,
    parameter int SNOOP_STREAK_MAX = 3,
    parameter int TIMEOUT_CYCLES   = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 l1_valid,
    output logic                 l1_ready,
    input  logic [CMDSIZE-1:0]   l1_cmd,
    input  logic [ADDR_BITS-1:0] l1_addr,
    input  logic                 snp_valid,
    output logic                 snp_ready,
    input  logic [CMDSIZE-1:0]   snp_cmd,
    input  logic [ADDR_BITS-1:0] snp_addr,
    output logic                 llc_cmd_valid,
    output logic [CMDSIZE-1:0]   llc_cmd,
    output logic [ADDR_BITS-1:0] llc_addr,
    input  logic                 llc_done,
    output logic                 busy,
    output logic                 err_illegal,
    output logic                 err_timeout
`ifdef LLC_SCHED_STATS_EN
    ,
    output logic [31:0]          stat_l1_issued,
    output logic [31:0]          stat_snp_issued,
    output logic [31:0]          stat_timeouts,
    output logic [31:0]          stat_illegal
`endif
);

    localparam int PW = $clog2(L1_FIFO_DEPTH);
    localparam int SW = $clog2(SNOOP_STREAK_MAX + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(SNOOP_STREAK_MAX);
    localparam logic [WW-1:0] WDOG_LAST  = WW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    function automatic logic f_l1_legal(input logic [CMDSIZE-1:0] c);
        return (c == CMDSIZE'(0)) || (c == CMDSIZE'(1)) || (c == CMDSIZE'(2)) ||
               (c == CMDSIZE'(8)) || (c == CMDSIZE'(9));
    endfunction

    function automatic logic f_snp_legal(input logic [CMDSIZE-1:0] c);
        return (c == CMDSIZE'(3)) || (c == CMDSIZE'(4)) || (c == CMDSIZE'(5)) || (c == CMDSIZE'(6));
    endfunction

    state_t               r_state, w_state_nxt;
    logic [CMDSIZE-1:0]   r_fifo_cmd  [L1_FIFO_DEPTH];
    logic [ADDR_BITS-1:0] r_fifo_addr [L1_FIFO_DEPTH];
    logic [PW:0]          r_wptr, r_rptr;
    logic                 r_snp_vld;
    logic [CMDSIZE-1:0]   r_snp_cmd;
    logic [ADDR_BITS-1:0] r_snp_addr;
    logic [CMDSIZE-1:0]   r_llc_cmd;
    logic [ADDR_BITS-1:0] r_llc_addr;
    logic [SW-1:0]        r_streak;
    logic [WW-1:0]        r_wdog;
    logic                 r_err_illegal, r_err_timeout;

    logic w_empty, w_full, w_l1_acc, w_snp_acc, w_push, w_snp_load, w_snp_win;
    logic w_grant_snp, w_grant_l1, w_timeout;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_l1_acc   = l1_valid && !w_full;
    assign w_snp_acc  = snp_valid && !r_snp_vld;
    assign w_push     = w_l1_acc && f_l1_legal(l1_cmd);
    assign w_snp_load = w_snp_acc && f_snp_legal(snp_cmd);
    assign w_snp_win  = r_snp_vld && (w_empty || (r_streak < STREAK_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_snp = 1'b0;
        w_grant_l1  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_snp_win) begin
                    w_grant_snp = 1'b1;
                    w_state_nxt = S_ISSUE;
                end else if (!w_empty) begin
                    w_grant_l1  = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (llc_done) begin
                    w_state_nxt = S_IDLE;
                end else if (r_wdog == WDOG_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Payload storage needs no reset: only the pointers define occupancy.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_cmd[r_wptr[PW-1:0]]  <= l1_cmd;
            r_fifo_addr[r_wptr[PW-1:0]] <= l1_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_snp_vld     <= 1'b0;
            r_snp_cmd     <= '0;
            r_snp_addr    <= '0;
            r_llc_cmd     <= '0;
            r_llc_addr    <= '0;
            r_streak      <= '0;
            r_wdog        <= '0;
            r_err_illegal <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            if (w_push)     r_wptr <= r_wptr + (PW+1)'(1);
            if (w_grant_l1) r_rptr <= r_rptr + (PW+1)'(1);
            if (w_grant_snp) r_snp_vld <= 1'b0;
            if (w_snp_load) begin
                r_snp_vld  <= 1'b1;
                r_snp_cmd  <= snp_cmd;
                r_snp_addr <= snp_addr;
            end
            if (w_grant_snp) begin
                r_llc_cmd  <= r_snp_cmd;
                r_llc_addr <= r_snp_addr;
            end else if (w_grant_l1) begin
                r_llc_cmd  <= r_fifo_cmd[r_rptr[PW-1:0]];
                r_llc_addr <= r_fifo_addr[r_rptr[PW-1:0]];
            end
            if (w_empty || w_grant_l1)                     r_streak <= '0;
            else if (w_grant_snp && r_streak != STREAK_MAX) r_streak <= r_streak + SW'(1);
            if (r_state == S_ISSUE)     r_wdog <= '0;
            else if (r_state == S_WAIT) r_wdog <= r_wdog + WW'(1);
            // Simultaneous drops on both ports collapse into one pulse.
            r_err_illegal <= (w_l1_acc && !f_l1_legal(l1_cmd)) || (w_snp_acc && !f_snp_legal(snp_cmd));
            r_err_timeout <= w_timeout;
        end
    end

`ifdef LLC_SCHED_STATS_EN
    logic [31:0] r_st_l1, r_st_snp, r_st_to, r_st_ill;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st_l1  <= '0;
            r_st_snp <= '0;
            r_st_to  <= '0;
            r_st_ill <= '0;
        end else begin
            if (w_grant_l1)    r_st_l1  <= r_st_l1 + 32'd1;
            if (w_grant_snp)   r_st_snp <= r_st_snp + 32'd1;
            if (r_err_timeout) r_st_to  <= r_st_to + 32'd1;
            if (r_err_illegal) r_st_ill <= r_st_ill + 32'd1;
        end
    end
    assign stat_l1_issued  = r_st_l1;
    assign stat_snp_issued = r_st_snp;
    assign stat_timeouts   = r_st_to;
    assign stat_illegal    = r_st_ill;
`endif

    assign l1_ready      = !w_full;
    assign snp_ready     = !r_snp_vld;
    assign llc_cmd_valid = (r_state == S_ISSUE);
    assign busy          = (r_state != S_IDLE);
    assign llc_cmd       = r_llc_cmd;
    assign llc_addr      = r_llc_addr;
    assign err_illegal   = r_err_illegal;
    assign err_timeout   = r_err_timeout;

endmodule

// File: tb/tb_llc_cmd_scheduler.sv
// Bench for llc_cmd_scheduler: directed scenarios plus randomized traffic checked against a
// queue-based transaction model of the scheduler.
module tb_llc_cmd_scheduler;
    localparam int DEPTH = 4;
    localparam int SMAX  = 3;
    localparam int TMO   = 64;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        l1_valid = 1'b0, snp_valid = 1'b0, llc_done = 1'b0;
    logic [3:0]  l1_cmd = '0, snp_cmd = '0;
    logic [31:0] l1_addr = '0, snp_addr = '0;
    logic        l1_ready, snp_ready, llc_cmd_valid, busy, err_illegal, err_timeout;
    logic [3:0]  llc_cmd;
    logic [31:0] llc_addr;
`ifdef LLC_SCHED_STATS_EN
    logic [31:0] stat_l1_issued, stat_snp_issued, stat_timeouts, stat_illegal;
`endif

    llc_cmd_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .l1_valid(l1_valid), .l1_ready(l1_ready), .l1_cmd(l1_cmd), .l1_addr(l1_addr),
        .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_cmd(snp_cmd), .snp_addr(snp_addr),
        .llc_cmd_valid(llc_cmd_valid), .llc_cmd(llc_cmd), .llc_addr(llc_addr),
        .llc_done(llc_done), .busy(busy), .err_illegal(err_illegal), .err_timeout(err_timeout)
`ifdef LLC_SCHED_STATS_EN
        , .stat_l1_issued(stat_l1_issued), .stat_snp_issued(stat_snp_issued),
        .stat_timeouts(stat_timeouts), .stat_illegal(stat_illegal)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_errors = 0;

    typedef struct packed {logic [3:0] c; logic [31:0] a;} req_t;

    // Observed issues and pulses.
    req_t iss_q[$];
    int   ill_cnt = 0, to_cnt = 0;
    always @(negedge clk) if (rst_n) begin
        if (llc_cmd_valid) iss_q.push_back({llc_cmd, llc_addr});
        if (err_illegal) ill_cnt++;
        if (err_timeout) to_cnt++;
    end

    // Transaction model: phase 0 idle, 1 issue, 2 wait.
    req_t m_q[$];
    req_t m_s, m_cur;
    bit   m_sv, m_ill, m_to;
    int   m_phase, m_wcnt, m_streak;

    function automatic bit l1_ok(logic [3:0] c); return c inside {4'd0, 4'd1, 4'd2, 4'd8, 4'd9}; endfunction
    function automatic bit snp_ok(logic [3:0] c); return c inside {[4'd3:4'd6]}; endfunction

    task automatic model_reset();
        m_q.delete(); m_sv = 0; m_s = '0; m_cur = '0; m_ill = 0; m_to = 0;
        m_phase = 0; m_wcnt = 0; m_streak = 0;
    endtask

    task automatic model_tick();
        bit l1acc, snpacc, sw, lw;
        int nq;
        if (!rst_n) begin model_reset(); return; end
        nq = m_q.size();
        l1acc = l1_valid && (nq < DEPTH);
        snpacc = snp_valid && !m_sv;
        sw = (m_phase == 0) && m_sv && (nq == 0 || m_streak < SMAX);
        lw = (m_phase == 0) && !sw && (nq > 0);
        m_ill = (l1acc && !l1_ok(l1_cmd)) || (snpacc && !snp_ok(snp_cmd));
        m_to = 0;
        if (m_phase == 0) begin
            if (sw || lw) m_phase = 1;
        end else if (m_phase == 1) begin
            m_phase = 2; m_wcnt = 0;
        end else if (llc_done) begin
            m_phase = 0;
        end else begin
            m_wcnt++;
            if (m_wcnt == TMO) begin m_to = 1; m_phase = 0; end
        end
        if (sw) begin m_cur = m_s; m_sv = 0; end
        if (lw) m_cur = m_q.pop_front();
        if (nq == 0 || lw) m_streak = 0;
        else if (sw && m_streak < SMAX) m_streak++;
        if (l1acc && l1_ok(l1_cmd)) m_q.push_back({l1_cmd, l1_addr});
        if (snpacc && snp_ok(snp_cmd)) begin m_sv = 1; m_s = {snp_cmd, snp_addr}; end
    endtask

    task automatic cycle();
        model_tick();
        @(posedge clk); @(negedge clk); #1;
    endtask

    task automatic idle_inputs();
        l1_valid = 0; snp_valid = 0; llc_done = 0; l1_cmd = 0; snp_cmd = 0; l1_addr = 0; snp_addr = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; idle_inputs(); model_reset();
        @(negedge clk); @(negedge clk);
        rst_n = 1; #1;
        iss_q.delete(); ill_cnt = 0; to_cnt = 0;
    endtask

    task automatic test_reset();
        idle_inputs(); rst_n = 0; #12;
        n_checks++; if ({l1_ready, snp_ready, llc_cmd_valid, busy, err_illegal, err_timeout} !== 6'b110000) begin
            n_errors++; $display("FAIL reset_flags: got %b exp 110000", {l1_ready, snp_ready, llc_cmd_valid, busy, err_illegal, err_timeout}); end
        n_checks++; if ({llc_cmd, llc_addr} !== 36'h0) begin
            n_errors++; $display("FAIL reset_cmd_addr: got %h/%h exp 0/0", llc_cmd, llc_addr); end
    endtask

    task automatic test_single_read();
        do_reset();
        l1_valid = 1; l1_cmd = 0; l1_addr = 32'h0000_1040;
        cycle(); l1_valid = 0;
        n_checks++; if ({llc_cmd_valid, busy} !== 2'b00) begin
            n_errors++; $display("FAIL single_accept_cycle: valid/busy %b exp 00", {llc_cmd_valid, busy}); end
        cycle();
        n_checks++; if ({llc_cmd_valid, busy, llc_cmd, llc_addr} !== {2'b11, 4'd0, 32'h0000_1040}) begin
            n_errors++; $display("FAIL single_issue: valid/busy %b cmd %h addr %h exp 11/0/00001040", {llc_cmd_valid, busy}, llc_cmd, llc_addr); end
        cycle();
        n_checks++; if ({llc_cmd_valid, busy, llc_addr} !== {2'b01, 32'h0000_1040}) begin
            n_errors++; $display("FAIL single_wait: valid/busy %b addr %h exp 01/00001040", {llc_cmd_valid, busy}, llc_addr); end
        repeat (3) cycle();
        llc_done = 1; cycle(); llc_done = 0;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL single_done: busy %b exp 0", busy); end
        l1_valid = 1; l1_cmd = 2; l1_addr = 32'h0000_2000;
        cycle(); l1_valid = 0; cycle();
        n_checks++; if ({llc_cmd_valid, llc_cmd, llc_addr} !== {1'b1, 4'd2, 32'h0000_2000}) begin
            n_errors++; $display("FAIL single_next_grant: valid %b cmd %h addr %h exp 1/2/00002000", llc_cmd_valid, llc_cmd, llc_addr); end
    endtask

    task automatic test_fifo_full();
        req_t exp_q[6];
        exp_q = '{{4'd0, 32'hA0}, {4'd1, 32'h100}, {4'd1, 32'h200}, {4'd1, 32'h300}, {4'd1, 32'h400}, {4'd1, 32'h500}};
        do_reset();
        l1_valid = 1; l1_cmd = 0; l1_addr = 32'hA0;
        cycle(); l1_valid = 0; cycle(); cycle();
        for (int i = 1; i <= 4; i++) begin
            l1_valid = 1; l1_cmd = 1; l1_addr = 32'(i * 256);
            cycle();
            if (i == 3) begin
                n_checks++; if (l1_ready !== 1'b1) begin n_errors++; $display("FAIL full_three_ready: %b exp 1", l1_ready); end
            end
        end
        n_checks++; if (l1_ready !== 1'b0) begin n_errors++; $display("FAIL full_four_ready: %b exp 0", l1_ready); end
        l1_addr = 32'h500;
        repeat (3) cycle();
        n_checks++; if ({l1_ready, busy} !== 2'b01) begin
            n_errors++; $display("FAIL full_held_off: ready/busy %b exp 01", {l1_ready, busy}); end
        llc_done = 1; cycle(); llc_done = 0;
        n_checks++; if ({l1_ready, busy} !== 2'b00) begin
            n_errors++; $display("FAIL full_after_done: ready/busy %b exp 00", {l1_ready, busy}); end
        cycle();
        n_checks++; if ({l1_ready, llc_cmd_valid} !== 2'b11) begin
            n_errors++; $display("FAIL full_pop_ready: ready/valid %b exp 11", {l1_ready, llc_cmd_valid}); end
        cycle(); l1_valid = 0;
        for (int i = 0; i < 60; i++) begin
            if (iss_q.size() == 6 && !busy) break;
            llc_done = busy && !llc_cmd_valid;
            cycle();
        end
        llc_done = 0;
        n_checks++; if (iss_q.size() != 6) begin
            n_errors++; $display("FAIL full_issue_count: got %0d exp 6", iss_q.size()); end
        else for (int i = 0; i < 6; i++) begin
            n_checks++; if (iss_q[i] !== exp_q[i]) begin
                n_errors++; $display("FAIL full_order[%0d]: got %h exp %h", i, iss_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_snoop_streak();
        logic [3:0] exp_c[8];
        exp_c = '{4'd4, 4'd4, 4'd4, 4'd0, 4'd4, 4'd4, 4'd4, 4'd0};
        do_reset();
        l1_valid = 1; l1_cmd = 0; l1_addr = 32'h1000;
        snp_valid = 1; snp_cmd = 4; snp_addr = 32'h8000;
        cycle();
        l1_addr = 32'h2000;
        cycle(); l1_valid = 0;
        for (int i = 0; i < 60; i++) begin
            if (iss_q.size() >= 8) break;
            llc_done = busy && !llc_cmd_valid;
            cycle();
        end
        llc_done = 0; snp_valid = 0;
        n_checks++; if (iss_q.size() < 8) begin
            n_errors++; $display("FAIL streak_issue_count: got %0d exp >=8", iss_q.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++; if (iss_q[i].c !== exp_c[i]) begin
                    n_errors++; $display("FAIL streak_order[%0d]: cmd %h exp %h", i, iss_q[i].c, exp_c[i]); end
            end
            n_checks++; if ({iss_q[3].a, iss_q[7].a} !== {32'h1000, 32'h2000}) begin
                n_errors++; $display("FAIL streak_l1_addr: %h %h exp 1000 2000", iss_q[3].a, iss_q[7].a); end
        end
    endtask

    task automatic test_illegal();
        do_reset();
        l1_valid = 1; l1_cmd = 7; l1_addr = 32'h77;
        snp_valid = 1; snp_cmd = 1; snp_addr = 32'h11;
        cycle(); idle_inputs();
        n_checks++; if ({err_illegal, l1_ready, snp_ready, busy} !== 4'b1110) begin
            n_errors++; $display("FAIL illegal_pulse: ill/l1r/snpr/busy %b exp 1110", {err_illegal, l1_ready, snp_ready, busy}); end
        cycle();
        n_checks++; if (err_illegal !== 1'b0) begin n_errors++; $display("FAIL illegal_one_cycle: %b exp 0", err_illegal); end
        repeat (4) cycle();
        n_checks++; if (iss_q.size() != 0 || busy !== 1'b0 || ill_cnt != 1) begin
            n_errors++; $display("FAIL illegal_no_issue: issues %0d busy %b pulses %0d exp 0/0/1", iss_q.size(), busy, ill_cnt); end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        l1_valid = 1; l1_cmd = 9; l1_addr = 32'h9000;
        cycle();
        l1_cmd = 2; l1_addr = 32'h2220;
        cycle(); l1_valid = 0;
        n_checks++; if ({llc_cmd_valid, llc_cmd} !== {1'b1, 4'd9}) begin
            n_errors++; $display("FAIL timeout_issue: valid %b cmd %h exp 1/9", llc_cmd_valid, llc_cmd); end
        n = 0;
        for (int i = 0; i < 100; i++) begin
            cycle(); n++;
            if (err_timeout) break;
        end
        n_checks++; if (n != TMO + 1 || err_timeout !== 1'b1) begin
            n_errors++; $display("FAIL timeout_latency: pulse after %0d cycles (seen %b) exp %0d", n, err_timeout, TMO + 1); end
        n_checks++; if ({busy, llc_cmd_valid} !== 2'b00) begin
            n_errors++; $display("FAIL timeout_idle: busy/valid %b exp 00", {busy, llc_cmd_valid}); end
        cycle();
        n_checks++; if ({llc_cmd_valid, llc_cmd, llc_addr, err_timeout} !== {1'b1, 4'd2, 32'h2220, 1'b0}) begin
            n_errors++; $display("FAIL timeout_next: valid %b cmd %h addr %h to %b exp 1/2/2220/0", llc_cmd_valid, llc_cmd, llc_addr, err_timeout); end
    endtask

    task automatic test_reset_midwait();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            l1_valid = 1; l1_cmd = 0; l1_addr = 32'(i * 16);
            cycle();
        end
        l1_valid = 0; cycle();
        n_checks++; if ({busy, llc_cmd_valid, llc_addr} !== {2'b10, 32'h10}) begin
            n_errors++; $display("FAIL midwait_pre: busy/valid %b addr %h exp 10/10", {busy, llc_cmd_valid}, llc_addr); end
        #2 rst_n = 0; #1;
        n_checks++; if ({l1_ready, snp_ready, llc_cmd_valid, busy, err_illegal, err_timeout, llc_cmd, llc_addr} !== {6'b110000, 36'h0}) begin
            n_errors++; $display("FAIL midwait_reset_outputs: flags %b cmd %h addr %h", {l1_ready, snp_ready, llc_cmd_valid, busy, err_illegal, err_timeout}, llc_cmd, llc_addr); end
        @(negedge clk); rst_n = 1; #1;
        iss_q.delete(); ill_cnt = 0; to_cnt = 0;
        llc_done = 1; cycle(); llc_done = 0;
        repeat (6) cycle();
        n_checks++; if (busy !== 1'b0 || iss_q.size() != 0 || l1_ready !== 1'b1 || to_cnt != 0 || ill_cnt != 0) begin
            n_errors++; $display("FAIL midwait_after: busy %b issues %0d l1r %b to %0d ill %0d exp 0/0/1/0/0", busy, iss_q.size(), l1_ready, to_cnt, ill_cnt); end
    endtask

    task automatic test_random();
        logic [3:0] legal_l1[5];
        logic [5:0] exp_f;
        legal_l1 = '{4'd0, 4'd1, 4'd2, 4'd8, 4'd9};
        do_reset();
        for (int i = 0; i < 900; i++) begin
            l1_valid = ($urandom_range(0, 99) < 45);
            l1_cmd = ($urandom_range(0, 9) != 0) ? legal_l1[$urandom_range(0, 4)] : 4'($urandom);
            l1_addr = $urandom;
            snp_valid = ($urandom_range(0, 99) < 30);
            snp_cmd = ($urandom_range(0, 9) != 0) ? 4'($urandom_range(3, 6)) : 4'($urandom);
            snp_addr = $urandom;
            llc_done = (((i / 150) % 2 == 1) && ((i % 150) < 90)) ? 1'b0 : ($urandom_range(0, 2) == 0);
            cycle();
            exp_f = {m_q.size() < DEPTH, !m_sv, m_phase == 1, m_phase != 0, m_ill, m_to};
            n_checks++; if ({l1_ready, snp_ready, llc_cmd_valid, busy, err_illegal, err_timeout} !== exp_f) begin
                n_errors++; $display("FAIL rand_flags@%0d: got %b exp %b", i, {l1_ready, snp_ready, llc_cmd_valid, busy, err_illegal, err_timeout}, exp_f); end
            n_checks++; if ({llc_cmd, llc_addr} !== m_cur) begin
                n_errors++; $display("FAIL rand_cmd_addr@%0d: got %h exp %h", i, {llc_cmd, llc_addr}, m_cur); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_fifo_full();
        test_snoop_streak();
        test_illegal();
        test_timeout();
        test_reset_midwait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end
endmodule
